sseg_decoder: RTL and testbench
===============================

SSEG_DECODER -- requirements
Module: sseg_decoder

Interface
REQ-001 Parameter: ACTIVE_LOW, default 0, 1 inverts every Cathode bit at the output register input.
REQ-002 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: Num  input  4  hex digit to display, 0x0-0xF.
REQ-005 Port: dp  input  1  decimal-point request, 1 = lit.
REQ-006 Port: blank  input  1  1 = all segments off.
REQ-007 Port: lamp_test  input  1  1 = all segments and dp lit.
REQ-008 Port: Cathode  output  8  segment drive, bit7 = dp, bits6..0 = g,f,e,d,c,b,a; registered.
REQ-009 Interface is fixed: one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-010 Segment encoding (ACTIVE_LOW=0) SHALL use 1 = segment lit.
REQ-011 Decoder SHALL produce bits6..0 per Num: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07.
REQ-012 Decoder SHALL continue: 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
REQ-013 Bit7 SHALL equal dp during normal decode.
REQ-014 Priority SHALL be lamp_test > blank > normal decode.
REQ-015 lamp_test=1 SHALL produce 0xFF regardless of Num, dp, blank.
REQ-016 blank=1 with lamp_test=0 SHALL produce 0x00 regardless of Num and dp.
REQ-017 Cathode SHALL update on every rising clk edge, with a latency of exactly one cycle from inputs to output; no enable, no handshake.
REQ-018 With ACTIVE_LOW=1, Cathode SHALL be the bitwise inverse of the ACTIVE_LOW=0 value in every case, including reset.
REQ-019 Input changes between edges SHALL NOT affect Cathode until the next rising edge.
REQ-020 Decoding SHALL be total over all 16 Num codes; no X or default-to-unknown outputs.

Reset
REQ-021 rst_n low SHALL force Cathode immediately, without waiting for clk, to all segments off: 0x00, or 0xFF when ACTIVE_LOW=1.
REQ-022 Cathode SHALL hold the off value while rst_n is low.
REQ-023 The first rising edge after rst_n deasserts SHALL load the decode of the current inputs.
REQ-024 Reset asserted mid-operation SHALL override any pending update.

Structure
REQ-025 The 16-entry segment table, the SEG_OFF and SEG_ALL constants, and the bit-position constants (DP=7, G..A=6..0) SHALL live in a shared package sseg_pkg.
REQ-026 The combinational digit-to-segment lookup SHALL be one sub-module, sseg_lut (4-bit in, 7-bit out).
REQ-027 sseg_decoder SHALL hold the priority mux, the polarity inversion, and the single 8-bit output register.

Verification
REQ-028 Reset: rst_n=0 mid-cycle -> Cathode=0x00 before the next edge; with ACTIVE_LOW=1 -> 0xFF.
REQ-029 Sweep: Num=0..F, dp=0, one per cycle -> Cathode equals the REQ-011/012 table one cycle later; Num=5 -> 8'b01101101.
REQ-030 dp: Num=8, dp=1 -> 0xFF; Num=1, dp=1 -> 0x86.
REQ-031 Priority: Num=5, blank=1 -> 0x00; Num=5, blank=1, lamp_test=1 -> 0xFF; release both -> 0x6D on the next edge.
REQ-032 Latency: change Num 3->7 just after an edge -> Cathode stays 0x4F until the following edge, then becomes 0x07.
REQ-033 Polarity: ACTIVE_LOW=1, Num=5, dp=0 -> Cathode=8'b10010010.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared seven-segment constants: bit positions, all-off/all-on patterns
// and the hex digit to segment table (1 = segment lit, bits 6..0 = g..a).
package sseg_pkg;

    localparam int SEG_DP = 7;
    localparam int SEG_G  = 6;
    localparam int SEG_F  = 5;
    localparam int SEG_E  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_C  = 2;
    localparam int SEG_B  = 1;
    localparam int SEG_A  = 0;

    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [7:0] SEG_ALL = 8'hFF;

    // Element [k] is the pattern for digit k; the leftmost entry is digit F.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/sseg_lut.sv
// Combinational hex digit to seven-segment lookup (active-high segments).
module sseg_lut
    import sseg_pkg::*;
(
    input  logic [3:0] num_i,
    output logic [6:0] seg_o
);

    // Every 4-bit code has a table entry, so the lookup is total.
    always_comb begin
        seg_o = SEG_TABLE[num_i];
    end

endmodule

// File: rtl/sseg_decoder.sv
// Registered seven-segment decoder with lamp test, blanking, decimal point
// and selectable output polarity. One cycle of latency from inputs to Cathode.
module sseg_decoder
    import sseg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Num,
    input  logic       dp,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [7:0] Cathode
);

    // XOR mask applied in front of the register; the reset value goes through
    // the same mask so "all off" means the same thing in both polarities.
    localparam logic [7:0] POL_MASK = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] OFF_Q    = SEG_OFF ^ POL_MASK;

    logic [6:0] seg_lut;
    logic [7:0] cathode_d;
    logic [7:0] cathode_q;

    sseg_lut u_lut (
        .num_i (Num),
        .seg_o (seg_lut)
    );

    // Priority select: lamp test beats blank beats normal decode, then polarity.
    always_comb begin
        cathode_d = SEG_OFF;
        if (lamp_test) begin
            cathode_d = SEG_ALL;
        end else if (blank) begin
            cathode_d = SEG_OFF;
        end else begin
            cathode_d         = {1'b0, seg_lut};
            cathode_d[SEG_DP] = dp;
        end
        cathode_d = cathode_d ^ POL_MASK;
    end

    // Single output register; async reset forces all segments off at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cathode_q <= OFF_Q;
        end else begin
            cathode_q <= cathode_d;
        end
    end

    assign Cathode = cathode_q;

endmodule

// File: tb/tb_sseg_decoder.sv
// Directed bench for sseg_decoder. Two instances share the stimulus: one with
// active-high segments and one with ACTIVE_LOW=1, whose output must always be
// the bitwise inverse of the active-high expectation.
module tb_sseg_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] num = 4'h0;
    logic       dp = 1'b0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic [7:0] cath_hi;
    logic [7:0] cath_lo;

    int checks = 0;
    int errors = 0;

    // Hand-written digit patterns, bits 6..0 = g..a.
    logic [6:0] exp_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    sseg_decoder #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .Num       (num),
        .dp        (dp),
        .blank     (blank),
        .lamp_test (lamp_test),
        .Cathode   (cath_hi)
    );

    sseg_decoder #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .Num       (num),
        .dp        (dp),
        .blank     (blank),
        .lamp_test (lamp_test),
        .Cathode   (cath_lo)
    );

    // Compare both instances against one active-high expectation.
    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (cath_hi === exp) else begin
            errors++;
            $error("FAIL %s hi observed %h expected %h", tag, cath_hi, exp);
        end
        checks++;
        assert (cath_lo === ~exp) else begin
            errors++;
            $error("FAIL %s lo observed %h expected %h", tag, cath_lo, ~exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later and check.
    task automatic step(input logic [3:0] n, input logic d, input logic b,
                        input logic l, input logic [7:0] exp, input string tag);
        num       = n;
        dp        = d;
        blank     = b;
        lamp_test = l;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        // Held in reset across edges with inputs that would light everything.
        num = 4'h8;
        dp  = 1'b1;
        @(posedge clk);
        #1;
        check("reset_first_edge", 8'h00);
        @(posedge clk);
        #1;
        check("reset_hold", 8'h00);

        // Release at the falling edge; the next rising edge loads the decode.
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_load", 8'hFF);

        // Full digit sweep with dp off.
        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b0, 1'b0, 1'b0, {1'b0, exp_tab[i]}, $sformatf("sweep_%0h", i));
        end
        step(4'h5, 1'b0, 1'b0, 1'b0, 8'b0110_1101, "digit5_bits");

        // Decimal point.
        step(4'h8, 1'b1, 1'b0, 1'b0, 8'hFF, "dp_8");
        step(4'h1, 1'b1, 1'b0, 1'b0, 8'h86, "dp_1");

        // Priority: blank, then lamp test over blank, lamp test alone, release.
        step(4'h5, 1'b0, 1'b1, 1'b0, 8'h00, "blank_5");
        step(4'h8, 1'b1, 1'b1, 1'b0, 8'h00, "blank_dp");
        step(4'h5, 1'b0, 1'b1, 1'b1, 8'hFF, "lamp_over_blank");
        step(4'h1, 1'b0, 1'b0, 1'b1, 8'hFF, "lamp_only");
        step(4'h5, 1'b0, 1'b0, 1'b0, 8'h6D, "release_5");

        // Latency: change just after an edge, output holds until the next one.
        step(4'h3, 1'b0, 1'b0, 1'b0, 8'h4F, "latency_3");
        num = 4'h7;
        #4;
        check("latency_hold", 8'h4F);
        @(posedge clk);
        #1;
        check("latency_7", 8'h07);

        // Mid-cycle reset clears at once and overrides the pending update.
        #4;
        rst_n = 1'b0;
        num   = 4'h9;
        #1;
        check("reset_midcycle", 8'h00);
        @(posedge clk);
        #1;
        check("reset_override", 8'h00);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_reload_9", 8'h6F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
